gpio_ctrl: RTL and testbench

Parametrised general-purpose I/O controller on the standard word-addressed bus slave interface (CS_, As_, RW, Addr, WrData, RdData, Rdy_).
- Adds three features: per-pin direction control; atomic set and clear writes; synchronised inputs with per-pin rising/falling edge interrupt capture.
- A single active-high irq line goes to the interrupt controller.
- Each pin drives a tristate pad at top level through gpio_out/gpio_oe.

---
 rtl/gpio_ctrl_pkg.sv | 26 ++
 rtl/gpio_ctrl_if.sv | 24 ++
 rtl/gpio_sync_edge.sv | 54 +++++
 rtl/gpio_ctrl.sv | 139 +++++++++++++
 tb/tb_gpio_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg
// Shared definitions for the GPIO controller: the word-address register map,
// the RW encoding of the bus and the levels of its active-low strobes.
package gpio_ctrl_pkg;

  // Word addresses decoded from Addr[2:0].
  typedef enum logic [2:0] {
    GPIO_ADDR_IN       = 3'd0,  // RO  synchronised pin values
    GPIO_ADDR_OUT      = 3'd1,  // RW  output data
    GPIO_ADDR_DIR      = 3'd2,  // RW  1 = output
    GPIO_ADDR_OUT_SET  = 3'd3,  // WO  OUT |= data
    GPIO_ADDR_OUT_CLR  = 3'd4,  // WO  OUT &= ~data
    GPIO_ADDR_RISE_EN  = 3'd5,  // RW  rising-edge capture enable
    GPIO_ADDR_FALL_EN  = 3'd6,  // RW  falling-edge capture enable
    GPIO_ADDR_IRQ_STAT = 3'd7   // R/W1C captured edge status
  } gpio_addr_e;

  // RW line encoding.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Levels of the active-low bus strobes (CS_, As_, Rdy_).
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage : gpio_ctrl_pkg

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if
// Word-addressed bus between a master and the GPIO controller.
//   CS_, As_  chip select / address strobe, active-low; access when both low
//   RW        1 = read, 0 = write
//   Addr      word address
//   WrData    write data
//   RdData    read data, valid in the Rdy_ cycle of a read, 0 otherwise
//   Rdy_      ready, active-low, one cycle after each access
interface gpio_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              CS_;
  logic              As_;
  logic              RW;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;
  logic              Rdy_;

  modport master (output CS_, As_, RW, Addr, WrData, input RdData, Rdy_);
  modport slave  (input CS_, As_, RW, Addr, WrData, output RdData, Rdy_);

endinterface : gpio_ctrl_if

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Multi-stage synchroniser for the asynchronous pad inputs followed by a
// per-pin rising/falling edge detector.
//   clk, reset  system clock, synchronous active-high reset
//   async_in    raw pad values
//   rise_en     per-pin rising-edge enable
//   fall_en     per-pin falling-edge enable
//   arm         edge events are suppressed while low (warm-up after reset)
//   sync_q      synchronised pin values (SYNC_STAGES cycles behind the pad)
//   edge_evt    per-pin enabled edge seen this cycle
module gpio_sync_edge #(
  parameter int CH          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] async_in,
  input  logic [CH-1:0] rise_en,
  input  logic [CH-1:0] fall_en,
  input  logic          arm,
  output logic [CH-1:0] sync_q,
  output logic [CH-1:0] edge_evt
);

  // Stage 0 samples the pad; stage SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][CH-1:0] stage_q, stage_d;
  logic [CH-1:0]                  prev_q, prev_d;

  // NOTE: every signal written here gets a value before any condition could
  // skip it; a path that leaves one unassigned would infer a latch.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], async_in};
    prev_d  = sync_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole chain is reset, unlike a RAM, so the detector starts
      // from a known all-zero history instead of X.
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_q   = stage_q[SYNC_STAGES-1];
  assign edge_evt = ((sync_q & ~prev_q & rise_en) |
                     (~sync_q & prev_q & fall_en)) & {CH{arm}};

endmodule : gpio_sync_edge

// File: rtl/gpio_ctrl.sv
// gpio_ctrl
// GPIO controller on the word-addressed bus: output data with atomic set/clear,
// per-pin direction, synchronised inputs and edge-capture interrupt status.
//   clk, reset  system clock, synchronous active-high reset
//   bus         slave side of gpio_ctrl_if (CS_, As_, RW, Addr, WrData,
//               RdData, Rdy_)
//   gpio_in     asynchronous pad inputs
//   gpio_out    output data register (OUT)
//   gpio_oe     pad output enable (DIR)
//   irq         OR of IRQ_STAT, active-high
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int CH          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  gpio_ctrl_if.slave    bus,
  input  logic [CH-1:0] gpio_in,
  output logic [CH-1:0] gpio_out,
  output logic [CH-1:0] gpio_oe,
  output logic          irq
);

  // Warm-up counter covers the synchroniser plus the previous-value flop, so
  // a pin that is already high when reset drops never looks like an edge.
  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [CH-1:0]     out_q, out_d;
  logic [CH-1:0]     dir_q, dir_d;
  logic [CH-1:0]     rise_en_q, rise_en_d;
  logic [CH-1:0]     fall_en_q, fall_en_d;
  logic [CH-1:0]     irq_stat_q, irq_stat_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_n_q, rdy_n_d;

  logic [CH-1:0] sync_q, edge_evt;
  logic [CH-1:0] wr_val, rd_val, w1c_mask;
  logic          acc, arm;
  gpio_addr_e    addr;

  // Only Addr[2:0] and WrData[CH-1:0] are decoded; the rest is ignored.
  logic [ADDR_W-1:0] unused_addr;
  logic [DATA_W-1:0] unused_wr_data;
  assign unused_addr    = bus.Addr;
  assign unused_wr_data = bus.WrData;

  assign arm = (warm_q == '0);

  gpio_sync_edge #(
    .CH          (CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (gpio_in),
    .rise_en  (rise_en_q),
    .fall_en  (fall_en_q),
    .arm      (arm),
    .sync_q   (sync_q),
    .edge_evt (edge_evt)
  );

  always_comb begin
    acc      = (bus.CS_ == ENABLE_) && (bus.As_ == ENABLE_);
    addr     = gpio_addr_e'(bus.Addr[2:0]);
    wr_val   = bus.WrData[CH-1:0];
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_mask  = '0;
    rd_val    = '0;
    warm_d    = arm ? warm_q : warm_q - WARM_W'(1);

    case (addr)
      GPIO_ADDR_IN:       rd_val = sync_q;
      GPIO_ADDR_OUT:      rd_val = out_q;
      GPIO_ADDR_DIR:      rd_val = dir_q;
      GPIO_ADDR_RISE_EN:  rd_val = rise_en_q;
      GPIO_ADDR_FALL_EN:  rd_val = fall_en_q;
      GPIO_ADDR_IRQ_STAT: rd_val = irq_stat_q;
      default:            rd_val = '0;  // OUT_SET / OUT_CLR are write-only
    endcase

    if (acc && bus.RW == WRITE) begin
      case (addr)
        GPIO_ADDR_OUT:      out_d     = wr_val;
        GPIO_ADDR_DIR:      dir_d     = wr_val;
        GPIO_ADDR_OUT_SET:  out_d     = out_q | wr_val;
        GPIO_ADDR_OUT_CLR:  out_d     = out_q & ~wr_val;
        GPIO_ADDR_RISE_EN:  rise_en_d = wr_val;
        GPIO_ADDR_FALL_EN:  fall_en_d = wr_val;
        GPIO_ADDR_IRQ_STAT: w1c_mask  = wr_val;
        default:            ;  // IN is read-only
      endcase
    end

    // Edge set is applied after the clear so a same-cycle event wins.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | edge_evt;

    rd_data_d = (acc && bus.RW == READ) ? DATA_W'(rd_val) : '0;
    rdy_n_d   = acc ? ENABLE_ : DISABLE_;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '1;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      warm_q     <= WARM_INIT;
      rd_data_q  <= '0;
      rdy_n_q    <= DISABLE_;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      warm_q     <= warm_d;
      rd_data_q  <= rd_data_d;
      rdy_n_q    <= rdy_n_d;
    end
  end

  assign bus.RdData = rd_data_q;
  assign bus.Rdy_   = rdy_n_q;
  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign irq        = |irq_stat_q;

endmodule : gpio_ctrl

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl
// Self-checking bench for gpio_ctrl. Two instances share one bus stimulus:
// a 16-pin build (main target) and a 5-pin build (width/reset corner cases).
// Directed vectors and hand-written sequences use constant expectations; a
// randomized phase compares the 16-pin build against a history-based model.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int SYNC = 2;

  logic        clk;
  logic        reset;
  logic        cs_n, as_n, rw;
  logic [29:0] addr_v;
  logic [31:0] wdata;
  logic [15:0] gpio_in16;
  logic [15:0] gpio_out16, gpio_oe16;
  logic [4:0]  gpio_out5, gpio_oe5;
  logic        irq16, irq5;

  int n_checks = 0;
  int n_errors = 0;
  bit model_chk = 0;

  gpio_ctrl_if #(.ADDR_W(30), .DATA_W(32)) bus16 ();
  gpio_ctrl_if #(.ADDR_W(30), .DATA_W(32)) bus5 ();

  assign bus16.CS_ = cs_n;   assign bus5.CS_ = cs_n;
  assign bus16.As_ = as_n;   assign bus5.As_ = as_n;
  assign bus16.RW  = rw;     assign bus5.RW  = rw;
  assign bus16.Addr = addr_v; assign bus5.Addr = addr_v;
  assign bus16.WrData = wdata; assign bus5.WrData = wdata;

  gpio_ctrl #(.CH(16), .SYNC_STAGES(SYNC), .ADDR_W(30), .DATA_W(32)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave),
    .gpio_in(gpio_in16), .gpio_out(gpio_out16), .gpio_oe(gpio_oe16), .irq(irq16)
  );

  gpio_ctrl #(.CH(5), .SYNC_STAGES(SYNC), .ADDR_W(30), .DATA_W(32)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5.slave),
    .gpio_in(gpio_in16[4:0]), .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .irq(irq5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge, returns at a negedge. One-cycle strobe, then checks
  // Rdy_ is low for exactly the following cycle and RdData returns to 0.
  task automatic bus_access(input logic rw_i, input logic [2:0] a, input logic [31:0] wd,
                            output logic [31:0] rd16, output logic [31:0] rd5);
    cs_n = 1'b0; as_n = 1'b0; rw = rw_i; addr_v = {27'd0, a}; wdata = wd;
    @(negedge clk);
    cs_n = 1'b1; as_n = 1'b1; rw = READ;
    check("rdy_low", 32'(bus16.Rdy_), 32'(ENABLE_));
    rd16 = bus16.RdData;
    rd5  = bus5.RdData;
    @(negedge clk);
    check("rdy_high", 32'(bus16.Rdy_), 32'(DISABLE_));
    check("rddata_idle", bus16.RdData, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for the 16-pin build: registers as plain variables, the
  // synchroniser as a queue of per-edge pad samples.
  // ---------------------------------------------------------------------------
  logic [15:0] m_out, m_dir, m_rise, m_fall, m_stat;
  logic        m_rdy_n;
  logic [31:0] m_rd;
  logic [15:0] m_hist[$];
  int          m_since;

  always @(posedge clk) begin : ref_model
    logic [15:0] sync_v, prev_v, evt, wv, rv;
    logic        acc;
    if (reset) begin
      m_out = 16'hFFFF; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0;
      m_rdy_n = 1'b1; m_rd = '0; m_since = 0;
      m_hist.delete();
      for (int i = 0; i < SYNC + 1; i++) m_hist.push_back(16'h0);
    end else begin
      // Pad value sampled j edges ago is m_hist[size-j].
      sync_v = m_hist[m_hist.size() - SYNC];
      prev_v = m_hist[m_hist.size() - SYNC - 1];
      evt = '0;
      if (m_since >= SYNC + 1) begin
        for (int p = 0; p < 16; p++) begin
          if (m_rise[p] && sync_v[p] && !prev_v[p]) evt[p] = 1'b1;
          if (m_fall[p] && !sync_v[p] && prev_v[p]) evt[p] = 1'b1;
        end
      end
      acc = !cs_n && !as_n;
      wv  = wdata[15:0];
      case (addr_v[2:0])
        3'd0: rv = sync_v;
        3'd1: rv = m_out;
        3'd2: rv = m_dir;
        3'd5: rv = m_rise;
        3'd6: rv = m_fall;
        3'd7: rv = m_stat;
        default: rv = '0;
      endcase
      m_rd    = (acc && rw) ? {16'h0, rv} : 32'h0;
      m_rdy_n = !acc;
      if (acc && !rw) begin
        case (addr_v[2:0])
          3'd1: m_out  = wv;
          3'd2: m_dir  = wv;
          3'd3: m_out  = m_out | wv;
          3'd4: m_out  = m_out & ~wv;
          3'd5: m_rise = wv;
          3'd6: m_fall = wv;
          3'd7: m_stat = m_stat & ~wv;
          default: ;
        endcase
      end
      m_stat = m_stat | evt;
      m_hist.push_back(gpio_in16);
      if (m_hist.size() > SYNC + 1) void'(m_hist.pop_front());
      if (m_since < 1000) m_since++;
    end
  end

  always @(negedge clk) begin
    if (model_chk) begin
      check("model_rdy", 32'(bus16.Rdy_), 32'(m_rdy_n));
      check("model_rddata", bus16.RdData, m_rd);
      check("model_gpio_out", 32'(gpio_out16), 32'(m_out));
      check("model_gpio_oe", 32'(gpio_oe16), 32'(m_dir));
      check("model_irq", 32'(irq16), 32'(m_stat != 16'h0));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;   // checked on reads only
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd16, rd5;
    bit          irq_seen;

    reset = 1'b1; cs_n = 1'b1; as_n = 1'b1; rw = READ;
    addr_v = '0; wdata = '0; gpio_in16 = '0;

    // Reset values and register map after reset.
    vecs.push_back('{READ,  3'd0, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd1, 32'h0,        32'h0000FFFF, 16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd2, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd3, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd4, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd5, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd6, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    vecs.push_back('{READ,  3'd7, 32'h0,        32'h0,      16'hFFFF, 16'h0000});
    // OUT, OUT_SET, OUT_CLR, DIR.
    vecs.push_back('{WRITE, 3'd1, 32'h000000F0, 32'h0,      16'h00F0, 16'h0000});
    vecs.push_back('{WRITE, 3'd3, 32'h00000003, 32'h0,      16'h00F3, 16'h0000});
    vecs.push_back('{WRITE, 3'd4, 32'h00000010, 32'h0,      16'h00E3, 16'h0000});
    vecs.push_back('{READ,  3'd1, 32'h0,        32'h000000E3, 16'h00E3, 16'h0000});
    vecs.push_back('{WRITE, 3'd2, 32'h000000FF, 32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{READ,  3'd2, 32'h0,        32'h000000FF, 16'h00E3, 16'h00FF});
    // Write-only reads 0, IN ignores writes, upper write bits ignored.
    vecs.push_back('{READ,  3'd3, 32'h0,        32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{WRITE, 3'd0, 32'h00001234, 32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{READ,  3'd0, 32'h0,        32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{WRITE, 3'd5, 32'hFFFF0005, 32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{READ,  3'd5, 32'h0,        32'h00000005, 16'h00E3, 16'h00FF});
    vecs.push_back('{WRITE, 3'd6, 32'hABCD0042, 32'h0,      16'h00E3, 16'h00FF});
    vecs.push_back('{READ,  3'd6, 32'h0,        32'h00000042, 16'h00E3, 16'h00FF});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rdy", 32'(bus16.Rdy_), 32'h1);
    check("reset_rddata", bus16.RdData, 32'h0);
    check("reset_gpio_out", 32'(gpio_out16), 32'h0000FFFF);
    check("reset_gpio_oe", 32'(gpio_oe16), 32'h0);
    check("reset_irq", 32'(irq16), 32'h0);

    foreach (vecs[i]) begin
      bus_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd16, rd5);
      if (vecs[i].rw == READ) check($sformatf("vec%0d_rd", i), rd16, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), 32'(gpio_out16), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_oe", i), 32'(gpio_oe16), 32'(vecs[i].exp_oe));
    end

    // Pin 0 high through reset, RISE_EN written on the first cycle after it.
    reset = 1'b1; gpio_in16 = 16'h0001;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_access(WRITE, 3'd5, 32'h1, rd16, rd5);
    irq_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (irq16) irq_seen = 1'b1;
    end
    check("warmup_irq_quiet", 32'(irq_seen), 32'h0);
    bus_access(READ, 3'd7, 32'h0, rd16, rd5);
    check("warmup_irq_stat", rd16, 32'h0);

    // Rise on pin 0, fall on pin 1: IN after 2 cycles, IRQ_STAT after 3.
    bus_access(WRITE, 3'd6, 32'h2, rd16, rd5);
    gpio_in16 = 16'h0002;
    repeat (6) @(negedge clk);
    bus_access(WRITE, 3'd7, 32'hFFFF, rd16, rd5);
    bus_access(READ, 3'd7, 32'h0, rd16, rd5);
    check("edge_pre_stat", rd16, 32'h0);
    gpio_in16 = 16'h0001;
    cs_n = 1'b0; as_n = 1'b0; rw = READ; addr_v = 30'd0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("edge_irq_c%0d", j + 1), 32'(irq16), (j == 2) ? 32'h1 : 32'h0);
      check($sformatf("edge_in_c%0d", j + 1), bus16.RdData, (j == 2) ? 32'h1 : 32'h2);
    end
    cs_n = 1'b1; as_n = 1'b1;
    @(negedge clk);
    bus_access(READ, 3'd7, 32'h0, rd16, rd5);
    check("edge_irq_stat", rd16, 32'h3);

    // W1C of bit 0 in the very cycle a new rise on pin 0 is captured.
    gpio_in16 = 16'h0000;
    repeat (6) @(negedge clk);
    gpio_in16 = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    cs_n = 1'b0; as_n = 1'b0; rw = WRITE; addr_v = 30'd7; wdata = 32'h1;
    @(negedge clk);
    cs_n = 1'b1; as_n = 1'b1; rw = READ;
    check("setwins_irq", 32'(irq16), 32'h1);
    @(negedge clk);
    bus_access(READ, 3'd7, 32'h0, rd16, rd5);
    check("setwins_stat", rd16, 32'h3);
    bus_access(WRITE, 3'd7, 32'h3, rd16, rd5);
    bus_access(READ, 3'd7, 32'h0, rd16, rd5);
    check("w1c_stat", rd16, 32'h0);
    check("w1c_irq", 32'(irq16), 32'h0);

    // 5-pin build: width masking, then reset during a write access.
    bus_access(WRITE, 3'd1, 32'hFFFFFFFF, rd16, rd5);
    bus_access(READ, 3'd1, 32'h0, rd16, rd5);
    check("ch5_out_read", rd5, 32'h0000001F);
    check("ch16_out_read", rd16, 32'h0000FFFF);
    bus_access(WRITE, 3'd1, 32'h0, rd16, rd5);
    check("ch5_out_zero", 32'(gpio_out5), 32'h0);
    reset = 1'b1;
    cs_n = 1'b0; as_n = 1'b0; rw = WRITE; addr_v = 30'd1; wdata = 32'h0000000A;
    @(negedge clk);
    check("rst_acc_rdy5", 32'(bus5.Rdy_), 32'h1);
    check("rst_acc_rdy16", 32'(bus16.Rdy_), 32'h1);
    check("rst_acc_out5", 32'(gpio_out5), 32'h1F);
    check("rst_acc_out16", 32'(gpio_out16), 32'hFFFF);
    reset = 1'b0; cs_n = 1'b1; as_n = 1'b1; rw = READ;
    @(negedge clk);
    bus_access(READ, 3'd1, 32'h0, rd16, rd5);
    check("rst_acc_read5", rd5, 32'h0000001F);

    // Randomized traffic against the model, including resets and held strobes.
    reset = 1'b1; gpio_in16 = 16'($urandom());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_chk = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) gpio_in16 = gpio_in16 ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        cs_n = 1'b0; as_n = 1'b0;
        rw = 1'($urandom());
        addr_v = 30'($urandom());
        wdata = $urandom();
      end else begin
        cs_n = 1'($urandom());
        as_n = 1'b1;
        rw = 1'($urandom());
        addr_v = 30'($urandom());
        wdata = $urandom();
      end
    end
    @(negedge clk);
    cs_n = 1'b1; as_n = 1'b1; reset = 1'b0;
    @(negedge clk);
    model_chk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gpio_ctrl
